// File: rtl/fetch_decode.sv
// Fetch/decode stage: owns the PC, assembles 1- and 2-byte instructions from a
// registered-read program ROM, resolves jumps locally and issues the rest.
module fetch_decode #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [7:0] MEM_TOP  = 8'h7F
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] mem_addr_o,
   input  logic [7:0] mem_data_i,
   input  logic [3:0] flags_i,
   output logic       instr_valid_o,
   input  logic       instr_ready_i,
   output logic [7:0] instr_opcode_o,
   output logic [7:0] instr_operand_o,
   output logic [7:0] pc_o,
   output logic       halted_o,
   output logic       fault_o
);

   typedef enum logic [2:0] {
      S_ADDR_OP,
      S_LAT_OP,
      S_ADDR_ARG,
      S_LAT_ARG,
      S_ISSUE,
      S_HALT
   } state_t;

   state_t     state_q;
   logic [7:0] pc_q;
   logic [7:0] opcode_q;
   logic [7:0] operand_q;
   logic       valid_q;
   logic       halted_q;
   logic       fault_q;
   logic       jump_taken;

   function automatic logic is_one_byte(input logic [7:0] op);
      return op inside {[8'h42:8'h49]};
   endfunction

   function automatic logic is_two_exec(input logic [7:0] op);
      return op inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97};
   endfunction

   function automatic logic is_jump(input logic [7:0] op);
      return op inside {[8'h20:8'h28]};
   endfunction

   // {N,Z,V,C} = flags_i[3:0]; opcode_q already holds the jump opcode here.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      jump_taken = 1'b0;
      case (opcode_q)
         8'h20:   jump_taken = 1'b1;
         8'h21:   jump_taken =  flags_i[3];
         8'h22:   jump_taken = ~flags_i[3];
         8'h23:   jump_taken =  flags_i[2];
         8'h24:   jump_taken = ~flags_i[2];
         8'h25:   jump_taken =  flags_i[1];
         8'h26:   jump_taken = ~flags_i[1];
         8'h27:   jump_taken =  flags_i[0];
         8'h28:   jump_taken = ~flags_i[0];
         default: jump_taken = 1'b0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only, so every branch
   // below sees the pre-edge values of all registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_ADDR_OP;
         pc_q      <= RESET_PC;
         opcode_q  <= 8'h00;
         operand_q <= 8'h00;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         case (state_q)
            S_ADDR_OP, S_ADDR_ARG: begin
               if (pc_q > MEM_TOP) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  fault_q  <= 1'b1;
               end else begin
                  state_q <= (state_q == S_ADDR_OP) ? S_LAT_OP : S_LAT_ARG;
               end
            end

            S_LAT_OP: begin
               opcode_q <= mem_data_i;
               if (mem_data_i == 8'h00) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else if (is_one_byte(mem_data_i)) begin
                  pc_q      <= pc_q + 8'd1;
                  operand_q <= 8'h00;
                  valid_q   <= 1'b1;
                  state_q   <= S_ISSUE;
               end else if (is_two_exec(mem_data_i) || is_jump(mem_data_i)) begin
                  pc_q    <= pc_q + 8'd1;
                  state_q <= S_ADDR_ARG;
               end else begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  fault_q  <= 1'b1;
               end
            end

            S_LAT_ARG: begin
               operand_q <= mem_data_i;
               if (is_jump(opcode_q)) begin
                  pc_q    <= jump_taken ? mem_data_i : pc_q + 8'd1;
                  state_q <= S_ADDR_OP;
               end else begin
                  pc_q    <= pc_q + 8'd1;
                  valid_q <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (instr_ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= S_ADDR_OP;
               end
            end

            S_HALT: begin
               valid_q <= 1'b0;
            end

            default: begin
               state_q  <= S_HALT;
               valid_q  <= 1'b0;
               halted_q <= 1'b1;
               fault_q  <= 1'b1;
            end
         endcase
      end
   end

   assign mem_addr_o      = pc_q;
   assign pc_o            = pc_q;
   assign instr_valid_o   = valid_q;
   assign instr_opcode_o  = opcode_q;
   assign instr_operand_o = operand_q;
   assign halted_o        = halted_q;
   assign fault_o         = fault_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed timing cases plus random programs compared
// against an instruction-level model of the program walk.
`timescale 1ns/1ps
module tb_fetch_decode;

   localparam logic [7:0] RESET_PC  = 8'h00;
   localparam logic [7:0] MEM_TOP   = 8'h7F;
   localparam int         MAX_STEPS = 48;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic [3:0] flags = 4'h0;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic [7:0] instr_opcode;
   logic [7:0] instr_operand;
   logic [7:0] pc;
   logic       halted;
   logic       fault;

   logic [7:0] rom [256];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] op;
      logic [7:0] arg;
      logic [7:0] pc_after;
   } issue_t;

   issue_t     exp_q[$];
   logic       model_halts;
   logic       model_fault;
   logic [7:0] model_pc;

   fetch_decode #(.RESET_PC(RESET_PC), .MEM_TOP(MEM_TOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr_o     (mem_addr),
      .mem_data_i     (mem_data),
      .flags_i        (flags),
      .instr_valid_o  (instr_valid),
      .instr_ready_i  (instr_ready),
      .instr_opcode_o (instr_opcode),
      .instr_operand_o(instr_operand),
      .pc_o           (pc),
      .halted_o       (halted),
      .fault_o        (fault)
   );

   always #5 clk = ~clk;

   // Synchronous program ROM: data appears one cycle after the address.
   always @(posedge clk) mem_data <= rom[mem_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pc"},      32'(pc), 32'(RESET_PC));
      check({tag, "_addr"},    32'(mem_addr), 32'(RESET_PC));
      check({tag, "_valid"},   32'(instr_valid), 32'd0);
      check({tag, "_opcode"},  32'(instr_opcode), 32'h00);
      check({tag, "_operand"}, 32'(instr_operand), 32'h00);
      check({tag, "_halted"},  32'(halted), 32'd0);
      check({tag, "_fault"},   32'(fault), 32'd0);
   endtask

   task automatic wait_for_op(input string tag, input logic [7:0] op);
      logic found = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (instr_valid && instr_opcode == op) begin
            found = 1'b1;
            break;
         end
      end
      check(tag, 32'(found), 32'd1);
   endtask

   // Reference model: a jump's condition from its opcode.
   function automatic logic model_taken(input logic [7:0] op, input logic [3:0] f);
      int         k;
      logic [1:0] fi;
      if (op == 8'h20) return 1'b1;
      k  = int'(op) - 33;
      fi = 2'(3 - k / 2);
      return f[fi] == ((k % 2) == 0);
   endfunction

   // Walks the program instruction by instruction, listing what must be issued.
   task automatic model_run(input logic [3:0] f);
      logic [7:0] mpc, op, arg;
      exp_q.delete();
      model_halts = 1'b0;
      model_fault = 1'b0;
      mpc = RESET_PC;
      for (int s = 0; s < MAX_STEPS; s++) begin
         if (mpc > MEM_TOP) begin
            model_halts = 1'b1; model_fault = 1'b1; break;
         end
         op = rom[mpc];
         if (op == 8'h00) begin
            model_halts = 1'b1; break;
         end
         if (op inside {[8'h42:8'h49]}) begin
            mpc = mpc + 8'd1;
            exp_q.push_back('{op, 8'h00, mpc});
            continue;
         end
         if (!(op inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, [8'h20:8'h28]})) begin
            model_halts = 1'b1; model_fault = 1'b1; break;
         end
         mpc = mpc + 8'd1;
         if (mpc > MEM_TOP) begin
            model_halts = 1'b1; model_fault = 1'b1; break;
         end
         arg = rom[mpc];
         mpc = mpc + 8'd1;
         if (op inside {[8'h20:8'h28]}) begin
            if (model_taken(op, f)) mpc = arg;
         end else begin
            exp_q.push_back('{op, arg, mpc});
         end
      end
      model_pc = mpc;
   endtask

   task automatic run_program(input string tag);
      int         idx = 0;
      logic       held = 1'b0;
      logic [7:0] held_op = 8'h00, held_arg = 8'h00, held_pc = 8'h00;
      model_run(flags);
      instr_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (halted) break;
         if (idx >= exp_q.size() && !model_halts) break;
         if (held) begin
            check({tag, "_stall_hold"}, {instr_valid, instr_opcode, instr_operand, pc},
                  {1'b1, held_op, held_arg, held_pc});
         end
         instr_ready = ($urandom_range(0, 9) < 7);
         held     = instr_valid && !instr_ready;
         held_op  = instr_opcode;
         held_arg = instr_operand;
         held_pc  = pc;
         if (instr_valid && instr_ready) begin
            if (idx < exp_q.size()) begin
               check({tag, "_issue"}, {instr_opcode, instr_operand, pc},
                     {exp_q[idx].op, exp_q[idx].arg, exp_q[idx].pc_after});
            end else begin
               check({tag, "_issue_count"}, 32'(idx + 1), 32'(exp_q.size()));
            end
            idx++;
         end
      end
      check({tag, "_issued"}, 32'(idx), 32'(exp_q.size()));
      if (model_halts) begin
         check({tag, "_end"}, {halted, fault, instr_valid, pc},
               {1'b1, model_fault, 1'b0, model_pc});
      end
      instr_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] jop;
      logic [1:0] fi;
      logic       exp_taken;

      // Reset state
      clear_rom();
      rst = 1'b1;
      step(2);
      check_reset_outputs("reset");

      // Two-byte instruction latency
      rom[0] = 8'h87; rom[1] = 8'hF0;
      instr_ready = 1'b1;
      do_reset();
      step(3);
      check("two_byte_early", 32'(instr_valid), 32'd0);
      step(1);
      check("two_byte_issue", {instr_valid, instr_opcode, instr_operand, pc},
            {1'b1, 8'h87, 8'hF0, 8'h02});
      step(1);
      check("two_byte_accepted", 32'(instr_valid), 32'd0);

      // Stall on one-byte 42, then conditional jump 23 at 05
      clear_rom();
      rom[0] = 8'h87; rom[1] = 8'hF0; rom[2] = 8'h86; rom[3] = 8'h11;
      rom[4] = 8'h42; rom[5] = 8'h23; rom[6] = 8'h0B; rom[7] = 8'h44;
      rom[8'h0B] = 8'h45;
      flags = 4'b0100;
      instr_ready = 1'b1;
      do_reset();
      wait_for_op("stall_reach_42", 8'h42);
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_hold", {instr_valid, instr_opcode, instr_operand, mem_addr},
               {1'b1, 8'h42, 8'h00, 8'h05});
      end
      instr_ready = 1'b1;
      step(1);
      check("stall_release", {instr_valid, mem_addr}, {1'b0, 8'h05});
      for (int e = 1; e <= 4; e++) begin
         step(1);
         check("jump23_no_valid", 32'(instr_valid), 32'd0);
      end
      check("jump23_target", 32'(mem_addr), 32'h0B);

      // Every jump opcode with both condition outcomes
      for (int j = 0; j < 9; j++) begin
         for (int p = 0; p < 2; p++) begin
            jop = 8'(8'h20 + j);
            clear_rom();
            rom[0] = jop; rom[1] = 8'h40; rom[2] = 8'h42; rom[8'h40] = 8'h43;
            flags = 4'($urandom);
            if (jop != 8'h20) begin
               fi = 2'(3 - (j - 1) / 2);
               flags[fi] = jop[0] ? p[0] : ~p[0];
            end
            exp_taken = (jop == 8'h20) || (p == 1);
            instr_ready = 1'b1;
            do_reset();
            step(3);
            check($sformatf("jump%0h_p%0d_mid", jop, p), 32'(instr_valid), 32'd0);
            step(1);
            check($sformatf("jump%0h_p%0d_addr", jop, p), {instr_valid, mem_addr},
                  {1'b0, exp_taken ? 8'h40 : 8'h02});
            wait_for_op($sformatf("jump%0h_p%0d_next", jop, p), exp_taken ? 8'h43 : 8'h42);
         end
      end

      // HALT: sticky, no fault
      clear_rom();
      rom[0] = 8'h42; rom[1] = 8'h00;
      instr_ready = 1'b1;
      do_reset();
      step(4);
      check("halt_before", 32'(halted), 32'd0);
      step(1);
      check("halt_enter", {halted, fault, pc}, {1'b1, 1'b0, 8'h01});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_sticky", {halted, fault, instr_valid, pc}, {1'b1, 1'b0, 1'b0, 8'h01});
      end
      rst = 1'b1;
      #1;
      check_reset_outputs("halt_rst");

      // Illegal opcode: sticky fault
      clear_rom();
      rom[0] = 8'h55;
      do_reset();
      step(1);
      check("illegal_before", 32'(halted), 32'd0);
      step(1);
      check("illegal_enter", {halted, fault, pc}, {1'b1, 1'b1, 8'h00});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("illegal_sticky", {halted, fault, instr_valid}, {1'b1, 1'b1, 1'b0});
      end
      rst = 1'b1;
      #1;
      check_reset_outputs("illegal_rst");

      // Running off the top of memory, and jumping above it
      clear_rom();
      rom[0] = 8'h20; rom[1] = 8'h7F; rom[8'h7F] = 8'h46;
      run_program("edge_7f");
      rom[1] = 8'h90;
      run_program("jump_90");

      // Asynchronous reset while issuing and while latching an operand
      clear_rom();
      rom[0] = 8'h87; rom[1] = 8'hF0;
      instr_ready = 1'b0;
      do_reset();
      step(4);
      check("pre_rst_issue", 32'(instr_valid), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_in_issue");
      @(negedge clk);
      rst = 1'b0;
      instr_ready = 1'b1;
      step(4);
      check("refetch_issue", {instr_valid, instr_opcode, instr_operand, pc},
            {1'b1, 8'h87, 8'hF0, 8'h02});
      do_reset();
      step(3);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_in_lat_arg");
      @(negedge clk);
      rst = 1'b0;
      step(4);
      check("refetch_after_arg", {instr_valid, instr_opcode, pc}, {1'b1, 8'h87, 8'h02});

      // Random programs
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 256; i++) begin
            int sel = int'($urandom_range(0, 99));
            if (sel < 30)      rom[i] = 8'h86 + 8'($urandom_range(0, 3)) + (($urandom_range(0, 2) == 0) ? 8'h10 : 8'h00);
            else if (sel < 55) rom[i] = 8'h42 + 8'($urandom_range(0, 7));
            else if (sel < 78) rom[i] = 8'h20 + 8'($urandom_range(0, 8));
            else if (sel < 82) rom[i] = 8'h00;
            else if (sel < 85) rom[i] = 8'h50 + 8'($urandom_range(0, 15));
            else if (sel < 93) rom[i] = 8'($urandom_range(0, 8'h7F));
            else               rom[i] = 8'($urandom);
         end
         flags = 4'($urandom);
         run_program($sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
